// File: rtl/rvfi_dmem_pkg.sv
// Shared types for the RVFI data-memory window checker.
//   err_code_e   : first-error cause reported on err_code
//   byte_state_e : lifecycle of one shadowed window byte
//   ORDER_W      : width of rvfi_order
package rvfi_dmem_pkg;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_RAW   = 2'd1,
    ERR_RAR   = 2'd2,
    ERR_ORDER = 2'd3
  } err_code_e;

  typedef enum logic [1:0] {
    BS_UNKNOWN  = 2'd0,
    BS_OBSERVED = 2'd1,
    BS_WRITTEN  = 2'd2
  } byte_state_e;

  localparam int ORDER_W = 64;

endpackage

// File: rtl/rvfi_dmem_window_check_if.sv
// Packed RVFI retire bundle (NRET channels, channel c in slice c).
//   master : the retiring core / bench drives all fields
//   slave  : the checker observes all fields
interface rvfi_dmem_window_check_if
  import rvfi_dmem_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NRET = 1
);
  logic [NRET-1:0]            rvfi_valid;
  logic [NRET*ORDER_W-1:0]    rvfi_order;
  logic [NRET*XLEN-1:0]       rvfi_mem_addr;
  logic [NRET*(XLEN/8)-1:0]   rvfi_mem_rmask;
  logic [NRET*(XLEN/8)-1:0]   rvfi_mem_wmask;
  logic [NRET*XLEN-1:0]       rvfi_mem_rdata;
  logic [NRET*XLEN-1:0]       rvfi_mem_wdata;

  modport master (
    output rvfi_valid, rvfi_order, rvfi_mem_addr, rvfi_mem_rmask,
           rvfi_mem_wmask, rvfi_mem_rdata, rvfi_mem_wdata
  );

  modport slave (
    input rvfi_valid, rvfi_order, rvfi_mem_addr, rvfi_mem_rmask,
          rvfi_mem_wmask, rvfi_mem_rdata, rvfi_mem_wdata
  );
endinterface

// File: rtl/rvfi_dmem_word_shadow.sv
// Shadow copy of one XLEN-wide window word.
// Ports:
//   clk, reset       : clock, synchronous active-high reset (clears byte states)
//   hit[c]           : channel c retires into this word this cycle
//   rmask/wmask      : packed per-channel byte masks
//   rdata/wdata      : packed per-channel data
//   mis_raw/mis_rar  : per-channel, per-byte mismatch against written/observed data
//   cmp_cnt          : number of byte compares performed this cycle
// Channels are folded in ascending order inside one combinational pass, so
// a later channel sees the shadow as left by the earlier ones.
module rvfi_dmem_word_shadow
  import rvfi_dmem_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NRET     = 1,
  parameter int RR_CHECK = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NRET-1:0]          hit,
  input  logic [NRET*(XLEN/8)-1:0] rmask,
  input  logic [NRET*(XLEN/8)-1:0] wmask,
  input  logic [NRET*XLEN-1:0]     rdata,
  input  logic [NRET*XLEN-1:0]     wdata,
  output logic [NRET*(XLEN/8)-1:0] mis_raw,
  output logic [NRET*(XLEN/8)-1:0] mis_rar,
  output logic [7:0]               cmp_cnt
);
  localparam int BYTES = XLEN / 8;

  byte_state_e st_q [BYTES];
  byte_state_e st_d [BYTES];
  logic [7:0]  sh_q [BYTES];
  logic [7:0]  sh_d [BYTES];

  always_comb begin
    st_d    = st_q;
    sh_d    = sh_q;
    mis_raw = '0;
    mis_rar = '0;
    cmp_cnt = '0;
    for (int c = 0; c < NRET; c++) begin
      for (int b = 0; b < BYTES; b++) begin
        // Read check first so a read-modify-write retire compares old data.
        if (hit[c] && rmask[c*BYTES+b]) begin
          if (st_d[b] != BS_UNKNOWN) begin
            cmp_cnt = cmp_cnt + 8'd1;
            if (rdata[c*XLEN+8*b +: 8] != sh_d[b]) begin
              if (st_d[b] == BS_WRITTEN) mis_raw[c*BYTES+b] = 1'b1;
              else                       mis_rar[c*BYTES+b] = 1'b1;
            end
          end else if (RR_CHECK != 0) begin
            sh_d[b] = rdata[c*XLEN+8*b +: 8];
            st_d[b] = BS_OBSERVED;
          end
        end
        if (hit[c] && wmask[c*BYTES+b]) begin
          sh_d[b] = wdata[c*XLEN+8*b +: 8];
          st_d[b] = BS_WRITTEN;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int b = 0; b < BYTES; b++) st_q[b] <= BS_UNKNOWN;
    end else begin
      st_q <= st_d;
    end
  end

  // Shadow bytes are meaningless while UNKNOWN, so they carry no reset.
  always_ff @(posedge clk) begin
    sh_q <= sh_d;
  end

endmodule

// File: rtl/rvfi_dmem_window_check.sv
// RVFI data-memory consistency checker over a window of NWORDS words.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   win_base    : word-aligned window base (modulo-2^XLEN window)
//   rvfi        : RVFI retire bundle (slave modport)
//   err         : sticky error flag
//   err_code    : first-error cause (err_code_e)
//   err_order   : rvfi_order of the first failing retire
//   err_chan    : channel of the first failing retire
//   err_byte    : window byte index of the first mismatch (0 for order errors)
//   rd_checked  : saturating count of byte reads compared against the shadow
module rvfi_dmem_window_check
  import rvfi_dmem_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int NRET       = 1,
  parameter int NWORDS     = 4,
  parameter int RR_CHECK   = 1,
  parameter int USE_ASSERT = 1
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [XLEN-1:0]                     win_base,
  rvfi_dmem_window_check_if.slave             rvfi,
  output logic                                err,
  output logic [1:0]                          err_code,
  output logic [ORDER_W-1:0]                  err_order,
  output logic [1:0]                          err_chan,
  output logic [$clog2(NWORDS*XLEN/8)-1:0]    err_byte,
  output logic [31:0]                         rd_checked
);
  localparam int BYTES     = XLEN / 8;
  localparam int BSH       = $clog2(BYTES);
  localparam int WIN_BYTES = NWORDS * BYTES;
  localparam int EBW       = $clog2(WIN_BYTES);

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [7:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {25'd0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  logic [NRET-1:0]           vld;
  logic [XLEN-1:0]           off [NRET];
  logic [NRET-1:0]           in_win;
  logic [NRET-1:0]           hit_w [NWORDS];
  logic [NRET*BYTES-1:0]     mis_raw [NWORDS];
  logic [NRET*BYTES-1:0]     mis_rar [NWORDS];
  logic [7:0]                cnt_w [NWORDS];
  logic [7:0]                cnt_tot;

  logic [NRET-1:0]           ord_err;
  logic                      have_c;
  logic [ORDER_W-1:0]        last_c;

  logic                      ev;
  err_code_e                 ev_code;
  logic [1:0]                ev_chan;
  logic [ORDER_W-1:0]        ev_order;
  logic [EBW-1:0]            ev_byte;

  logic                      err_q, err_d;
  err_code_e                 err_code_q, err_code_d;
  logic [ORDER_W-1:0]        err_order_q, err_order_d;
  logic [1:0]                err_chan_q, err_chan_d;
  logic [EBW-1:0]            err_byte_q, err_byte_d;
  logic [31:0]               rd_checked_q, rd_checked_d;
  logic                      have_q, have_d;
  logic [ORDER_W-1:0]        last_q, last_d;

  // Retires seen during reset are dropped entirely.
  assign vld = rvfi.rvfi_valid & {NRET{~reset}};

  always_comb begin
    for (int c = 0; c < NRET; c++) begin
      off[c]    = (rvfi.rvfi_mem_addr[c*XLEN +: XLEN] & ~XLEN'(BYTES-1)) - win_base;
      in_win[c] = vld[c] && (off[c] < XLEN'(WIN_BYTES));
    end
    for (int w = 0; w < NWORDS; w++) begin
      for (int c = 0; c < NRET; c++) begin
        hit_w[w][c] = in_win[c] && ((off[c] >> BSH) == XLEN'(w));
      end
    end
  end

  for (genvar w = 0; w < NWORDS; w++) begin : g_word
    rvfi_dmem_word_shadow #(
      .XLEN     (XLEN),
      .NRET     (NRET),
      .RR_CHECK (RR_CHECK)
    ) u_word (
      .clk     (clk),
      .reset   (reset),
      .hit     (hit_w[w]),
      .rmask   (rvfi.rvfi_mem_rmask),
      .wmask   (rvfi.rvfi_mem_wmask),
      .rdata   (rvfi.rvfi_mem_rdata),
      .wdata   (rvfi.rvfi_mem_wdata),
      .mis_raw (mis_raw[w]),
      .mis_rar (mis_rar[w]),
      .cmp_cnt (cnt_w[w])
    );
  end

  always_comb begin
    cnt_tot = '0;
    for (int w = 0; w < NWORDS; w++) cnt_tot = cnt_tot + cnt_w[w];
  end

  // Order tracker chained across channels: channel k is checked against k-1.
  always_comb begin
    have_c  = have_q;
    last_c  = last_q;
    ord_err = '0;
    for (int c = 0; c < NRET; c++) begin
      if (vld[c]) begin
        if (have_c && (rvfi.rvfi_order[c*ORDER_W +: ORDER_W] != last_c + 64'd1)) ord_err[c] = 1'b1;
        have_c = 1'b1;
        last_c = rvfi.rvfi_order[c*ORDER_W +: ORDER_W];
      end
    end
    have_d = have_c;
    last_d = last_c;
  end

  // Pick the winning error this cycle: lowest channel, then order before data,
  // then lowest window byte.
  always_comb begin
    ev       = 1'b0;
    ev_code  = ERR_NONE;
    ev_chan  = '0;
    ev_order = '0;
    ev_byte  = '0;
    for (int c = 0; c < NRET; c++) begin
      if (!ev && ord_err[c]) begin
        ev       = 1'b1;
        ev_code  = ERR_ORDER;
        ev_chan  = 2'(c);
        ev_order = rvfi.rvfi_order[c*ORDER_W +: ORDER_W];
        ev_byte  = '0;
      end
      for (int w = 0; w < NWORDS; w++) begin
        for (int b = 0; b < BYTES; b++) begin
          if (!ev && (mis_raw[w][c*BYTES+b] || mis_rar[w][c*BYTES+b])) begin
            ev       = 1'b1;
            ev_code  = mis_raw[w][c*BYTES+b] ? ERR_RAW : ERR_RAR;
            ev_chan  = 2'(c);
            ev_order = rvfi.rvfi_order[c*ORDER_W +: ORDER_W];
            ev_byte  = EBW'(w*BYTES + b);
          end
        end
      end
    end
  end

  always_comb begin
    err_d       = err_q;
    err_code_d  = err_code_q;
    err_order_d = err_order_q;
    err_chan_d  = err_chan_q;
    err_byte_d  = err_byte_q;
    if (ev && !err_q) begin
      err_d       = 1'b1;
      err_code_d  = ev_code;
      err_order_d = ev_order;
      err_chan_d  = ev_chan;
      err_byte_d  = ev_byte;
    end
    rd_checked_d = sat_add(rd_checked_q, cnt_tot);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q        <= 1'b0;
      err_code_q   <= ERR_NONE;
      err_order_q  <= '0;
      err_chan_q   <= '0;
      err_byte_q   <= '0;
      rd_checked_q <= '0;
      have_q       <= 1'b0;
      last_q       <= '0;
    end else begin
      err_q        <= err_d;
      err_code_q   <= err_code_d;
      err_order_q  <= err_order_d;
      err_chan_q   <= err_chan_d;
      err_byte_q   <= err_byte_d;
      rd_checked_q <= rd_checked_d;
      have_q       <= have_d;
      last_q       <= last_d;
    end
  end

  assign err        = err_q;
  assign err_code   = err_code_q;
  assign err_order  = err_order_q;
  assign err_chan   = err_chan_q;
  assign err_byte   = err_byte_q;
  assign rd_checked = rd_checked_q;

  if (USE_ASSERT != 0) begin : g_assert
    a_no_error: assert property (@(posedge clk) disable iff (reset) !ev);
  end

endmodule

// File: tb/tb_rvfi_dmem_window_check.sv
module tb_rvfi_dmem_window_check;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] win_base = 32'h100;
  logic        err;
  logic [1:0]  err_code;
  logic [63:0] err_order;
  logic [1:0]  err_chan;
  logic [3:0]  err_byte;
  logic [31:0] rd_checked;

  rvfi_dmem_window_check_if #(.XLEN(32), .NRET(2)) bus ();

  rvfi_dmem_window_check #(
    .XLEN(32), .NRET(2), .NWORDS(4), .RR_CHECK(1), .USE_ASSERT(0)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .win_base   (win_base),
    .rvfi       (bus),
    .err        (err),
    .err_code   (err_code),
    .err_order  (err_order),
    .err_chan   (err_chan),
    .err_byte   (err_byte),
    .rd_checked (rd_checked)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Reference model: a 16-byte window addressed by byte offset from base.
  int          m_st [16];   // 0 unknown, 1 observed, 2 written
  logic [7:0]  m_sh [16];
  bit          m_have;
  logic [63:0] m_last;
  bit          m_err;
  logic [1:0]  m_code;
  logic [63:0] m_order;
  logic [1:0]  m_chan;
  logic [3:0]  m_byte;
  logic [31:0] m_rd;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    if (act === exp) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic note_err(input int code, input logic [63:0] ord, input int c, input int idx);
    if (!m_err) begin
      m_err = 1'b1; m_code = 2'(code); m_order = ord; m_chan = 2'(c); m_byte = 4'(idx);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_st[i] = 0;
    m_have = 0; m_last = '0; m_err = 0; m_code = '0; m_order = '0;
    m_chan = '0; m_byte = '0; m_rd = '0;
  endtask

  task automatic model_retire(input int c, input logic [63:0] ord, input logic [31:0] addr,
                              input logic [3:0] rm, input logic [3:0] wm,
                              input logic [31:0] rd, input logic [31:0] wd);
    logic [31:0] idx;
    if (m_have && ord != m_last + 64'd1) note_err(3, ord, c, 0);
    m_have = 1; m_last = ord;
    for (int b = 0; b < 4; b++) begin
      idx = (addr & 32'hFFFF_FFFC) + 32'(b) - win_base;
      if (idx < 32'd16) begin
        if (rm[b]) begin
          if (m_st[idx] != 0) begin
            m_rd++;
            if (rd[8*b +: 8] != m_sh[idx]) note_err(m_st[idx] == 2 ? 1 : 2, ord, c, int'(idx));
          end else begin
            m_sh[idx] = rd[8*b +: 8]; m_st[idx] = 1;
          end
        end
        if (wm[b]) begin
          m_sh[idx] = wd[8*b +: 8]; m_st[idx] = 2;
        end
      end
    end
  endtask

  task automatic model_cycle(input bit r);
    if (r) model_reset();
    else
      for (int c = 0; c < 2; c++)
        if (bus.rvfi_valid[c])
          model_retire(c, bus.rvfi_order[c*64 +: 64], bus.rvfi_mem_addr[c*32 +: 32],
                       bus.rvfi_mem_rmask[c*4 +: 4], bus.rvfi_mem_wmask[c*4 +: 4],
                       bus.rvfi_mem_rdata[c*32 +: 32], bus.rvfi_mem_wdata[c*32 +: 32]);
  endtask

  task automatic clear_bus();
    bus.rvfi_valid = '0; bus.rvfi_order = '0; bus.rvfi_mem_addr = '0;
    bus.rvfi_mem_rmask = '0; bus.rvfi_mem_wmask = '0;
    bus.rvfi_mem_rdata = '0; bus.rvfi_mem_wdata = '0;
  endtask

  task automatic set_ch(input int c, input logic [63:0] o, input logic [31:0] a,
                        input logic [3:0] rm, input logic [3:0] wm,
                        input logic [31:0] rd, input logic [31:0] wd);
    bus.rvfi_valid[c] = 1'b1;
    bus.rvfi_order[c*64 +: 64] = o;
    bus.rvfi_mem_addr[c*32 +: 32] = a;
    bus.rvfi_mem_rmask[c*4 +: 4] = rm;
    bus.rvfi_mem_wmask[c*4 +: 4] = wm;
    bus.rvfi_mem_rdata[c*32 +: 32] = rd;
    bus.rvfi_mem_wdata[c*32 +: 32] = wd;
  endtask

  task automatic step(input bit r);
    reset = r;
    @(posedge clk);
    model_cycle(r);
    #1;
    clear_bus();
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model.err", err, m_err);
      chk("model.err_code", err_code, m_code);
      chk("model.err_order", err_order, m_order);
      chk("model.err_chan", err_chan, m_chan);
      chk("model.err_byte", err_byte, m_byte);
      chk("model.rd_checked", rd_checked, m_rd);
    end
  end

  initial begin
    clear_bus();
    model_reset();
    step(1); step(1);
    chk_en = 1'b1;
    chk("reset.err", err, 0);
    chk("reset.rd_checked", rd_checked, 0);
    chk("reset.err_code", err_code, 0);

    // Store then matching load
    set_ch(0, 0, 32'h104, 4'h0, 4'hF, 0, 32'hDEADBEEF); step(0);
    set_ch(0, 1, 32'h104, 4'hF, 4'h0, 32'hDEADBEEF, 0); step(0);
    chk("raw_ok.err", err, 0);
    chk("raw_ok.rd_checked", rd_checked, 4);
    // Mismatching load
    set_ch(0, 2, 32'h104, 4'hF, 4'h0, 32'hDEADBE00, 0); step(0);
    chk("raw_bad.err", err, 1);
    chk("raw_bad.code", err_code, 1);
    chk("raw_bad.byte", err_byte, 4);
    chk("raw_bad.order", err_order, 2);
    chk("raw_bad.rd_checked", rd_checked, 8);
    step(1);

    // Read-after-read
    set_ch(0, 0, 32'h108, 4'hF, 4'h0, 32'h11223344, 0); step(0);
    chk("rar_first.rd_checked", rd_checked, 0);
    set_ch(0, 1, 32'h108, 4'hF, 4'h0, 32'h11223345, 0); step(0);
    chk("rar.code", err_code, 2);
    chk("rar.byte", err_byte, 8);
    chk("rar.rd_checked", rd_checked, 4);
    step(1);

    // Same-cycle forwarding ch0 -> ch1, then dual mismatch priority
    set_ch(0, 0, 32'h100, 4'h0, 4'h1, 0, 32'h000000AA);
    set_ch(1, 1, 32'h100, 4'h1, 4'h0, 32'h000000AA, 0); step(0);
    chk("fwd.err", err, 0);
    chk("fwd.rd_checked", rd_checked, 1);
    set_ch(0, 2, 32'h100, 4'h1, 4'h0, 32'h000000AB, 0);
    set_ch(1, 3, 32'h100, 4'h1, 4'h0, 32'h000000AC, 0); step(0);
    chk("prio.chan", err_chan, 0);
    chk("prio.order", err_order, 2);
    chk("prio.rd_checked", rd_checked, 3);
    step(1);

    // Order checking
    set_ch(0, 5, 32'h0, 4'h0, 4'h0, 0, 0); step(0);
    set_ch(0, 6, 32'h0, 4'h0, 4'h0, 0, 0); step(0);
    chk("ord_ok.err", err, 0);
    set_ch(0, 8, 32'h0, 4'h0, 4'h0, 0, 0); step(0);
    chk("ord.code", err_code, 3);
    chk("ord.order", err_order, 8);
    chk("ord.byte", err_byte, 0);
    step(1);
    chk("rst.err", err, 0);
    chk("rst.code", err_code, 0);
    chk("rst.order", err_order, 0);
    chk("rst.chan", err_chan, 0);
    set_ch(0, 100, 32'h0, 4'h0, 4'h0, 0, 0); step(0);
    chk("ord_after_rst.err", err, 0);
    set_ch(0, 101, 32'h0, 4'h0, 4'h0, 0, 0);
    set_ch(1, 103, 32'h0, 4'h0, 4'h0, 0, 0); step(0);
    chk("ord_ch1.chan", err_chan, 1);
    chk("ord_ch1.order", err_order, 103);
    step(1);

    // Window edge, read-modify-write, unaligned address
    set_ch(0, 0, 32'h10C, 4'h0, 4'hF, 0, 32'h01020304); step(0);
    set_ch(0, 1, 32'h10C, 4'hF, 4'hF, 32'h01020304, 32'hA5A5A5A5); step(0);
    set_ch(0, 2, 32'h10E, 4'hC, 4'h0, 32'hA5A50000, 0); step(0);
    chk("rmw.err", err, 0);
    chk("rmw.rd_checked", rd_checked, 6);
    set_ch(0, 3, 32'h110, 4'h0, 4'hF, 0, 32'h12345678); step(0);
    set_ch(0, 4, 32'h110, 4'hF, 4'h0, 32'h0, 0); step(0);
    set_ch(0, 5, 32'h0FC, 4'hF, 4'h0, 32'h0, 0); step(0);
    chk("outside.err", err, 0);
    chk("outside.rd_checked", rd_checked, 6);
    set_ch(0, 6, 32'h10C, 4'hF, 4'h0, 32'hA5A5A5A4, 0); step(0);
    chk("edge.code", err_code, 1);
    chk("edge.byte", err_byte, 12);

    // Window wrapping past address 0
    win_base = 32'hFFFF_FFF8;
    step(1);
    set_ch(0, 0, 32'hFFFF_FFFC, 4'h0, 4'hF, 0, 32'hCAFEF00D); step(0);
    set_ch(0, 1, 32'h0, 4'h0, 4'hF, 0, 32'h0BADC0DE); step(0);
    set_ch(0, 2, 32'h0, 4'hF, 4'h0, 32'h0BADC0DE, 0); step(0);
    set_ch(0, 3, 32'hFFFF_FFFC, 4'hF, 4'h0, 32'hCAFEF00D, 0); step(0);
    chk("wrap.err", err, 0);
    chk("wrap.rd_checked", rd_checked, 8);
    set_ch(0, 4, 32'h4, 4'h1, 4'h0, 32'h77, 0); step(0);
    set_ch(0, 5, 32'h4, 4'h1, 4'h0, 32'h78, 0); step(0);
    chk("wrap_rar.code", err_code, 2);
    chk("wrap_rar.byte", err_byte, 12);
    step(0);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
    $finish;
  end

endmodule
